// File: rtl/fwrisc_mem_arbiter_pkg.sv
// fwrisc_mem_arbiter_pkg
//   Shared types and constants for the fwrisc two-to-one memory arbiter.
//   - state_t : grant FSM states (idle, serving fetch, serving data)
//   - grant_t : identifies which requester owns or last owned the memory port
//   - FETCH_STRB : byte strobes presented to memory for every instruction fetch
package fwrisc_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [3:0] FETCH_STRB = 4'hF;

endpackage

// File: rtl/fwrisc_arb2.sv
// fwrisc_arb2
//   Combinational two-way picker between the instruction (I) and data (D)
//   requesters. The result is only meaningful when at least one request is
//   present; the caller decides whether a grant actually happens.
// Ports:
//   req_i      in   fetch request
//   req_d      in   data request
//   last_grant in   requester that won the previous access
//   mode       in   0 = round-robin, 1 = fixed priority with D winning
//   gnt        out  selected requester
module fwrisc_arb2
    import fwrisc_mem_arbiter_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last_grant,
    input  logic   mode,
    output grant_t gnt
);

    // On a tie, round-robin hands the port to whoever did not win last time,
    // which gives strict alternation under continuous contention.
    always_comb begin
        gnt = GNT_I;
        if (req_i && req_d) begin
            if (mode) begin
                gnt = GNT_D;
            end else if (last_grant == GNT_I) begin
                gnt = GNT_D;
            end else begin
                gnt = GNT_I;
            end
        end else if (req_d) begin
            gnt = GNT_D;
        end else begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter
//   Shares one memory port between the fwrisc fetch bus and data bus. A
//   registered grant FSM serialises accesses; the memory request fields are
//   latched on grant and held until the memory completes. Responses are
//   steered back to the requester that owns the current access.
// Parameters:
//   PRIORITY_MODE  0 = round-robin between I and D, 1 = fixed, D beats I
//   MAX_WAIT       BUSY cycles without completion before timeout pulses
// Ports:
//   clock, reset               clock and asynchronous active-high reset
//   iaddr/ivalid               fetch request; iready/idata fetch response
//   daddr/dwdata/dstrb/dwrite/dvalid   data request; dready/drdata response
//   maddr/mwdata/mstrb/mwrite/mvalid   registered memory request
//   mready/mrdata              memory completion and read data
//   timeout                    one-cycle pulse when an access hits MAX_WAIT
module fwrisc_mem_arbiter
    import fwrisc_mem_arbiter_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_WAIT      = 255
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic        iready,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dstrb,
    input  logic        dwrite,
    input  logic        dvalid,
    output logic        dready,
    output logic [31:0] drdata,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mstrb,
    output logic        mwrite,
    output logic        mvalid,
    input  logic        mready,
    input  logic [31:0] mrdata,
    output logic        timeout
);

    localparam logic        MODE_FIXED = (PRIORITY_MODE != 0);
    localparam logic [15:0] MAX_WAIT_W = 16'(MAX_WAIT);

    state_t      state;
    state_t      state_next;
    grant_t      last_grant;
    grant_t      gnt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_inc;
    logic        start;

    fwrisc_arb2 u_arb (
        .req_i      (ivalid),
        .req_d      (dvalid),
        .last_grant (last_grant),
        .mode       (MODE_FIXED),
        .gnt        (gnt)
    );

    assign start    = (state == IDLE) && (ivalid || dvalid);
    assign wait_inc = wait_cnt + 16'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every access passes back through IDLE, so a request that arrives while
    // busy is arbitrated fairly against the other requester afterwards.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ivalid || dvalid) begin
                    state_next = (gnt == GNT_D) ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory request registers, grant history and wait counter. The timeout
    // pulse is raised on the edge where the counter steps onto MAX_WAIT, so it
    // is high during the cycle the counter holds that value and never again
    // for the same access; the access itself keeps waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_D;
            wait_cnt   <= 16'd0;
            maddr      <= 32'd0;
            mwdata     <= 32'd0;
            mstrb      <= 4'd0;
            mwrite     <= 1'b0;
            mvalid     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (start) begin
                last_grant <= gnt;
                wait_cnt   <= 16'd0;
                mvalid     <= 1'b1;
                if (gnt == GNT_D) begin
                    maddr  <= daddr;
                    mwdata <= dwdata;
                    mstrb  <= dstrb;
                    mwrite <= dwrite;
                end else begin
                    maddr  <= iaddr;
                    mwdata <= 32'd0;
                    mstrb  <= FETCH_STRB;
                    mwrite <= 1'b0;
                end
            end else if (state != IDLE) begin
                if (mready) begin
                    mvalid <= 1'b0;
                end else if (wait_cnt != 16'hFFFF) begin
                    wait_cnt <= wait_inc;
                    if (wait_inc == MAX_WAIT_W) begin
                        timeout <= 1'b1;
                    end
                end
            end
        end
    end

    assign iready = (state == BUSY_I) && mready;
    assign dready = (state == BUSY_D) && mready;
    assign idata  = (state == BUSY_I) ? mrdata : 32'd0;
    assign drdata = (state == BUSY_D) ? mrdata : 32'd0;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// tb_fwrisc_mem_arbiter
//   Scoreboard bench for fwrisc_mem_arbiter. The stimulus process pushes the
//   response it expects for each access; a monitor pops and compares whenever
//   iready or dready is presented. A second, fixed-priority instance shares the
//   inputs and is only observed during the contention sequence.
module tb_fwrisc_mem_arbiter;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        write;
        logic [31:0] rdata;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [3:0]  dstrb;
    logic        ivalid, dvalid, dwrite, mready;

    logic        iready, dready, mwrite, mvalid, timeout;
    logic [31:0] idata, drdata, maddr, mwdata;
    logic [3:0]  mstrb;

    logic        iready1, dready1, mwrite1, mvalid1, timeout1;
    logic [31:0] idata1, drdata1, maddr1, mwdata1;
    logic [3:0]  mstrb1;

    exp_t sb[$];
    exp_t mon_e;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    logic rr_window    = 1'b0;
    logic mvalid1_prev = 1'b0;
    int   d1_grants    = 0;

    always #5 clock = ~clock;

    fwrisc_mem_arbiter #(.PRIORITY_MODE(0), .MAX_WAIT(3)) dut (
        .clock(clock), .reset(reset),
        .iaddr(iaddr), .ivalid(ivalid), .iready(iready), .idata(idata),
        .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb), .dwrite(dwrite),
        .dvalid(dvalid), .dready(dready), .drdata(drdata),
        .maddr(maddr), .mwdata(mwdata), .mstrb(mstrb), .mwrite(mwrite),
        .mvalid(mvalid), .mready(mready), .mrdata(mrdata), .timeout(timeout)
    );

    fwrisc_mem_arbiter #(.PRIORITY_MODE(1), .MAX_WAIT(3)) dut_fixed (
        .clock(clock), .reset(reset),
        .iaddr(iaddr), .ivalid(ivalid), .iready(iready1), .idata(idata1),
        .daddr(daddr), .dwdata(dwdata), .dstrb(dstrb), .dwrite(dwrite),
        .dvalid(dvalid), .dready(dready1), .drdata(drdata1),
        .maddr(maddr1), .mwdata(mwdata1), .mstrb(mstrb1), .mwrite(mwrite1),
        .mvalid(mvalid1), .mready(mready), .mrdata(mrdata), .timeout(timeout1)
    );

    function automatic void check_output(input string name, input logic [31:0] act,
                                         input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endfunction

    // Response monitor: each ready pulse must match the oldest expected access.
    always @(negedge clock) begin
        if (!reset && (iready || dready)) begin
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_ready: iready=%0b dready=%0b, required no response",
                         iready, dready);
            end else begin
                mon_e = sb.pop_front();
                check_output("ready_port", {31'd0, dready}, {31'd0, mon_e.is_d});
                check_output("other_ready", {31'd0, mon_e.is_d ? iready : dready}, 32'd0);
                check_output("ready_data", mon_e.is_d ? drdata : idata, mon_e.rdata);
                check_output("maddr", maddr, mon_e.addr);
                check_output("mwdata", mwdata, mon_e.wdata);
                check_output("mstrb", {28'd0, mstrb}, {28'd0, mon_e.strb});
                check_output("mwrite", {31'd0, mwrite}, {31'd0, mon_e.write});
            end
        end
    end

    // Fixed-priority instance: every grant during contention must go to D.
    always @(negedge clock) begin
        if (rr_window && mvalid1 && !mvalid1_prev) begin
            check_output("fixed_grant_addr", maddr1, 32'h400);
            d1_grants++;
        end
        mvalid1_prev = mvalid1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        iaddr = 32'd0; ivalid = 1'b0;
        daddr = 32'd0; dwdata = 32'd0; dstrb = 4'd0; dwrite = 1'b0; dvalid = 1'b0;
        mready = 1'b0; mrdata = 32'd0;
    endtask

    // One complete access from IDLE: request, grant, `waits` stalled cycles,
    // then completion. Called one time unit after a rising edge.
    task automatic apply_stimulus(input logic is_d, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  input logic write, input logic [31:0] rdata,
                                  input int waits);
        exp_t e;
        e.is_d  = is_d;
        e.addr  = addr;
        e.rdata = rdata;
        if (is_d) begin
            dvalid = 1'b1; daddr = addr; dwdata = wdata; dstrb = strb; dwrite = write;
            e.wdata = wdata; e.strb = strb; e.write = write;
        end else begin
            ivalid = 1'b1; iaddr = addr;
            e.wdata = 32'd0; e.strb = 4'hF; e.write = 1'b0;
        end
        sb.push_back(e);
        #2 check_output("pre_grant_mvalid", {31'd0, mvalid}, 32'd0);
        step();
        for (int k = 1; k <= waits + 1; k++) begin
            if (k == waits + 1) begin
                mready = 1'b1;
                mrdata = rdata;
            end
            #2;
            check_output("busy_mvalid", {31'd0, mvalid}, 32'd1);
            check_output("busy_maddr", maddr, addr);
            check_output("busy_timeout", {31'd0, timeout}, (k == 4) ? 32'd1 : 32'd0);
            step();
        end
        mready = 1'b0;
        ivalid = 1'b0;
        dvalid = 1'b0;
        #2 check_output("post_mvalid", {31'd0, mvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rr_data [4];
        exp_t e;
        rr_data = '{32'hA1, 32'hB2, 32'hA3, 32'hB4};

        reset = 1'b1;
        clear_inputs();
        step();
        step();
        check_output("rst_mvalid", {31'd0, mvalid}, 32'd0);
        check_output("rst_maddr", maddr, 32'd0);
        check_output("rst_mstrb", {28'd0, mstrb}, 32'd0);
        check_output("rst_iready", {31'd0, iready}, 32'd0);
        check_output("rst_timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        step();

        $display("[TB] fetch only");
        apply_stimulus(1'b0, 32'h100, 32'd0, 4'd0, 1'b0, 32'h13, 0);
        step();

        $display("[TB] store");
        apply_stimulus(1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1'b1, 32'h55, 0);
        step();

        $display("[TB] mready while idle");
        mready = 1'b1; mrdata = 32'hFFFF_0000;
        step();
        step();
        check_output("idle_mready_mvalid", {31'd0, mvalid}, 32'd0);
        mready = 1'b0;
        step();

        $display("[TB] round-robin contention");
        reset = 1'b1;
        step();
        reset = 1'b0;
        rr_window = 1'b1;
        ivalid = 1'b1; iaddr = 32'h300;
        dvalid = 1'b1; daddr = 32'h400; dwdata = 32'h1111_1111; dstrb = 4'hF; dwrite = 1'b0;
        for (int n = 0; n < 4; n++) begin
            e.is_d  = (n % 2) == 1;
            e.addr  = e.is_d ? 32'h400 : 32'h300;
            e.wdata = e.is_d ? 32'h1111_1111 : 32'd0;
            e.strb  = 4'hF;
            e.write = 1'b0;
            e.rdata = rr_data[n];
            sb.push_back(e);
        end
        for (int n = 0; n < 4; n++) begin
            #2 check_output("rr_idle_mvalid", {31'd0, mvalid}, 32'd0);
            step();
            #2 check_output("rr_grant_mvalid", {31'd0, mvalid}, 32'd1);
            mready = 1'b1;
            mrdata = rr_data[n];
            step();
            mready = 1'b0;
        end
        ivalid = 1'b0;
        dvalid = 1'b0;
        step();
        rr_window = 1'b0;
        check_output("fixed_grant_count", d1_grants, 32'd4);

        $display("[TB] wait states and timeout");
        apply_stimulus(1'b0, 32'h0000_0840, 32'd0, 4'd0, 1'b0, 32'h0BAD_F00D, 5);
        step();

        $display("[TB] reset mid-access");
        dvalid = 1'b1; daddr = 32'h500; dwdata = 32'hCAFE_0000; dstrb = 4'hF; dwrite = 1'b1;
        step();
        #2 check_output("mid_grant_mvalid", {31'd0, mvalid}, 32'd1);
        step();
        reset = 1'b1;
        dvalid = 1'b0;
        #1;
        check_output("mid_rst_mvalid", {31'd0, mvalid}, 32'd0);
        check_output("mid_rst_dready", {31'd0, dready}, 32'd0);
        check_output("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        step();
        reset = 1'b0;
        dvalid = 1'b1; daddr = 32'h504; dwrite = 1'b0; dstrb = 4'hF; dwdata = 32'd0;
        apply_stimulus(1'b0, 32'h508, 32'd0, 4'd0, 1'b0, 32'h77, 0);
        step();

        $display("[TB] dropped fetch request");
        ivalid = 1'b1; iaddr = 32'h600;
        e.is_d = 1'b0; e.addr = 32'h600; e.wdata = 32'd0; e.strb = 4'hF; e.write = 1'b0;
        e.rdata = 32'h66;
        sb.push_back(e);
        step();
        #2 check_output("drop_grant_mvalid", {31'd0, mvalid}, 32'd1);
        ivalid = 1'b0;
        dvalid = 1'b1; daddr = 32'h700; dwdata = 32'h1234_5678; dstrb = 4'b1100; dwrite = 1'b1;
        step();
        mready = 1'b1; mrdata = 32'h66;
        step();
        mready = 1'b0;
        #2 check_output("drop_idle_mvalid", {31'd0, mvalid}, 32'd0);
        e.is_d = 1'b1; e.addr = 32'h700; e.wdata = 32'h1234_5678; e.strb = 4'b1100;
        e.write = 1'b1; e.rdata = 32'h99;
        sb.push_back(e);
        step();
        #2 check_output("drop_next_maddr", maddr, 32'h700);
        mready = 1'b1; mrdata = 32'h99;
        step();
        mready = 1'b0;
        dvalid = 1'b0;
        step();
        step();

        check_output("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
